// File: rtl/bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_master_if
// Purpose  : Core request/response and pad-ring bus bundle for bus_master.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_en;
    logic        bus_wen;
    logic [1:0]  bus_size;
    logic [15:0] bus_addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        bus_ready;

    modport master (
        input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        input  load_data, bus_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_en, bus_wen, bus_size, bus_addr, store_data
    );

    modport slave (
        output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        output load_data, bus_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_en, bus_wen, bus_size, bus_addr, store_data
    );
endinterface
`default_nettype wire

// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_master
// Purpose  : Single-outstanding load/store master with alignment check,
//            lane replication/extraction and bus_ready timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire          clk,
    input  wire          a_reset_l,
    bus_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_en_q, bus_en_d;
    logic        bus_wen_q, bus_wen_d;
    logic [1:0]  bus_size_q, bus_size_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic        ld_signed_q, ld_signed_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        misaligned;
    logic [31:0] wdata_lanes;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [7:0]  cnt_inc;

    // Request-side decode: alignment and store lane replication
    always_comb begin
        misaligned  = 1'b0;
        wdata_lanes = bus.req_wdata;
        case (bus.req_size)
            2'b00: wdata_lanes = {4{bus.req_wdata[7:0]}};
            2'b01: begin
                wdata_lanes = {2{bus.req_wdata[15:0]}};
                misaligned  = bus.req_addr[0];
            end
            2'b10: misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Load extraction uses the registered access attributes, not the live request
    always_comb begin
        ld_byte = bus.load_data[7:0];
        case (bus_addr_q[1:0])
            2'b00:   ld_byte = bus.load_data[7:0];
            2'b01:   ld_byte = bus.load_data[15:8];
            2'b10:   ld_byte = bus.load_data[23:16];
            default: ld_byte = bus.load_data[31:24];
        endcase
        ld_half = bus_addr_q[1] ? bus.load_data[31:16] : bus.load_data[15:0];
        case (bus_size_q)
            2'b00:   ld_ext = {{24{ld_signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_signed_q & ld_half[15]}}, ld_half};
            default: ld_ext = bus.load_data;
        endcase
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_en_d     = bus_en_q;
        bus_wen_d    = bus_wen_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        store_data_d = store_data_q;
        ld_signed_d  = ld_signed_q;
        rsp_rdata_d  = 32'd0;
        rsp_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d      = ACCESS;
                        cnt_d        = 8'd0;
                        bus_en_d     = 1'b1;
                        bus_wen_d    = bus.req_wen;
                        bus_size_d   = bus.req_size;
                        bus_addr_d   = bus.req_addr;
                        store_data_d = wdata_lanes;
                        ld_signed_d  = bus.req_signed;
                    end
                end
            end
            ACCESS: begin
                if (bus.bus_ready) begin
                    state_d     = RESP;
                    bus_en_d    = 1'b0;
                    bus_wen_d   = 1'b0;
                    rsp_rdata_d = bus_wen_q ? 32'd0 : ld_ext;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == C_TIMEOUT) begin
                        state_d   = RESP;
                        bus_en_d  = 1'b0;
                        bus_wen_d = 1'b0;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            bus_en_q     <= 1'b0;
            bus_wen_q    <= 1'b0;
            bus_size_q   <= 2'b00;
            bus_addr_q   <= 16'd0;
            store_data_q <= 32'd0;
            ld_signed_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_en_q     <= bus_en_d;
            bus_wen_q    <= bus_wen_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            store_data_q <= store_data_d;
            ld_signed_q  <= ld_signed_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && a_reset_l;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.bus_en     = bus_en_q;
    assign bus.bus_wen    = bus_wen_q;
    assign bus.bus_size   = bus_size_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.store_data = store_data_q;
endmodule
`default_nettype wire
